ps2_key_decoder: RTL

- Consumes the byte stream from the PS/2 receiver (one byte plus a one-cycle valid strobe) and decodes Set-2 make/break sequences into Tetris control events.
- Tracks the held state of seven game keys and emits one-cycle action pulses.
- Generates its own auto-repeat (DAS) for left/right/down; keyboard typematic repeats are ignored.
- Sits between the PS/2 receiver and the game FSM, in the CLOCK_50 domain.

---
 rtl/ps2_key_decoder_if.sv | 29 ++
 rtl/ps2_key_decoder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder_if.sv
// ============================================================================
// Module   : ps2_key_decoder_if
// Purpose  : Byte-stream input and key-state output bundle for the decoder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface ps2_key_decoder_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [6:0] key_held;
   logic [6:0] key_pulse;

   modport master (
      output rx_data,
      output rx_valid,
      input  key_held,
      input  key_pulse
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output key_held,
      output key_pulse
   );
endinterface

`default_nettype wire

// File: rtl/ps2_key_decoder.sv
// ============================================================================
// Module   : ps2_key_decoder
// Purpose  : Set-2 make/break decoder producing Tetris key state, press pulses
//            and auto-repeat pulses for left/right/down.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_key_decoder #(
   parameter int unsigned REPEAT_DELAY  = 8000000,
   parameter int unsigned REPEAT_PERIOD = 2500000,
   parameter int unsigned CNT_W         = 24
) (
   input logic              CLOCK_50,
   input logic              reset,
   ps2_key_decoder_if.slave bus
);

   localparam logic [CNT_W-1:0] c_delay_load  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] c_period_load = CNT_W'(REPEAT_PERIOD - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_EXT     = 3'd1,
      S_BRK     = 3'd2,
      S_EXT_BRK = 3'd3,
      S_SKIP    = 3'd4
   } state_t;

   state_t     r_state;
   logic [2:0] r_skip;
   logic [8:0] r_src;
   logic [6:0] r_key_held;
   logic [6:0] r_key_pulse;

   logic [8:0] w_make_src;
   logic [8:0] w_brk_src;
   logic [8:0] w_src_next;
   logic [6:0] w_held_next;
   logic [6:0] w_press;
   logic [6:0] w_rep_fire;

   // Source slots: 0 left, 1 right, 2 down, 3 up-arrow, 4 X, 5 Z, 6 space, 7 P, 8 Esc
   function automatic logic [8:0] f_plain_src(input logic [7:0] code);
      logic [8:0] v;
      v = '0;
      case (code)
         8'h22:   v[4] = 1'b1;
         8'h1A:   v[5] = 1'b1;
         8'h29:   v[6] = 1'b1;
         8'h4D:   v[7] = 1'b1;
         8'h76:   v[8] = 1'b1;
         default: v = '0;
      endcase
      return v;
   endfunction

   function automatic logic [8:0] f_ext_src(input logic [7:0] code);
      logic [8:0] v;
      v = '0;
      case (code)
         8'h6B:   v[0] = 1'b1;
         8'h74:   v[1] = 1'b1;
         8'h72:   v[2] = 1'b1;
         8'h75:   v[3] = 1'b1;
         default: v = '0;
      endcase
      return v;
   endfunction

   // Prefix bytes (E0/F0/E1) map to no source, so no extra filtering is needed.
   always_comb begin
      w_make_src = '0;
      w_brk_src  = '0;
      if (bus.rx_valid) begin
         case (r_state)
            S_IDLE:    w_make_src = f_plain_src(bus.rx_data);
            S_EXT:     w_make_src = f_ext_src(bus.rx_data);
            S_BRK:     w_brk_src  = f_plain_src(bus.rx_data);
            S_EXT_BRK: w_brk_src  = f_ext_src(bus.rx_data);
            default:   w_make_src = '0;
         endcase
      end
      w_src_next  = (r_src | w_make_src) & ~w_brk_src;
      w_held_next = {w_src_next[8] | w_src_next[7], w_src_next[6], w_src_next[5],
                     w_src_next[4] | w_src_next[3], w_src_next[2:0]};
      w_press     = w_held_next & ~r_key_held;
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_skip      <= 3'd0;
         r_src       <= '0;
         r_key_held  <= '0;
         r_key_pulse <= '0;
      end else begin
         r_src       <= w_src_next;
         r_key_held  <= w_held_next;
         r_key_pulse <= w_press | w_rep_fire;
         if (bus.rx_valid) begin
            case (r_state)
               S_IDLE: begin
                  case (bus.rx_data)
                     8'hE0:   r_state <= S_EXT;
                     8'hF0:   r_state <= S_BRK;
                     8'hE1: begin
                        r_state <= S_SKIP;
                        r_skip  <= 3'd7;
                     end
                     default: r_state <= S_IDLE;
                  endcase
               end
               S_EXT: begin
                  if (bus.rx_data == 8'hF0)      r_state <= S_EXT_BRK;
                  else if (bus.rx_data == 8'hE0) r_state <= S_EXT;
                  else                           r_state <= S_IDLE;
               end
               S_SKIP: begin
                  if (r_skip <= 3'd1) begin
                     r_skip  <= 3'd0;
                     r_state <= S_IDLE;
                  end else begin
                     r_skip  <= r_skip - 3'd1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Break clears the counter before expiry is considered, so a release always wins.
   for (genvar gi = 0; gi < 3; gi++) begin : g_repeat
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge CLOCK_50 or posedge reset) begin
         if (reset)                 r_cnt <= '0;
         else if (!w_held_next[gi]) r_cnt <= '0;
         else if (w_press[gi])      r_cnt <= c_delay_load;
         else if (r_cnt == '0)      r_cnt <= c_period_load;
         else                       r_cnt <= r_cnt - CNT_W'(1);
      end

      assign w_rep_fire[gi] = r_key_held[gi] & w_held_next[gi] & (r_cnt == '0);
   end

   assign w_rep_fire[6:3] = 4'b0000;

   assign bus.key_held  = r_key_held;
   assign bus.key_pulse = r_key_pulse;

endmodule

`default_nettype wire
